// File: rtl/mem_definitions.sv
// Shared memory-access definitions for the pipeline.
// Contents:
//   mem_op_t    - memory operation carried with an instruction (NONE/LOAD/STORE)
//   mem_size_t  - access width and load extension (BYTE, HALF, WORD, BYTE_U, HALF_U)
//   mas_state_t - state of the memory-access stage FSM
//   is_misaligned() / lane_mask() - address/size helpers for a 4-lane word
package mem_definitions;

   typedef enum logic [1:0] {
      OP_NONE  = 2'd0,
      OP_LOAD  = 2'd1,
      OP_STORE = 2'd2
   } mem_op_t;

   typedef enum logic [2:0] {
      SZ_BYTE   = 3'd0,
      SZ_HALF   = 3'd1,
      SZ_WORD   = 3'd2,
      SZ_BYTE_U = 3'd3,
      SZ_HALF_U = 3'd4
   } mem_size_t;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } mas_state_t;

   // Undefined size codes are treated as WORD everywhere.
   function automatic logic is_misaligned(mem_size_t sz, logic [1:0] off);
      case (sz)
         SZ_BYTE, SZ_BYTE_U: return 1'b0;
         SZ_HALF, SZ_HALF_U: return off[0];
         default:            return (off != 2'b00);
      endcase
   endfunction

   function automatic logic [3:0] lane_mask(mem_size_t sz, logic [1:0] off);
      case (sz)
         SZ_BYTE, SZ_BYTE_U: return 4'b0001 << off;
         SZ_HALF, SZ_HALF_U: return 4'b0011 << off;
         default:            return 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the memory-access stage (master) and memory (slave).
// Signals:
//   mem_req   master->slave  request active
//   mem_we    master->slave  write strobe (store)
//   mem_addr  master->slave  word-aligned address
//   mem_wdata master->slave  lane-replicated store data
//   mem_be    master->slave  byte enables
//   mem_rdata slave->master  read data, valid when mem_ready is high
//   mem_ready slave->master  completes the current request
// Handshake: a request is raised with mem_req=1 and all master outputs held
// stable until the rising edge where mem_ready=1 is sampled; that edge completes
// the transfer. mem_ready sampled while mem_req=0 has no effect.
interface mem_access_stage_if #(
   parameter int D_WIDTH = 32,
   parameter int A_WIDTH = 32
);
   logic                   mem_req;
   logic                   mem_we;
   logic [A_WIDTH-1:0]     mem_addr;
   logic [D_WIDTH-1:0]     mem_wdata;
   logic [D_WIDTH/8-1:0]   mem_be;
   logic [D_WIDTH-1:0]     mem_rdata;
   logic                   mem_ready;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/load_aligner.sv
// Combinational load lane extraction and extension.
// Ports:
//   rdata    in  raw memory word
//   addr_lo  in  byte offset within the word
//   mem_size in  access size / extension kind
//   data     out selected lane, sign- or zero-extended to D_WIDTH
module load_aligner
   import mem_definitions::*;
#(
   parameter int D_WIDTH = 32
) (
   input  logic [D_WIDTH-1:0] rdata,
   input  logic [1:0]         addr_lo,
   input  mem_size_t          mem_size,
   output logic [D_WIDTH-1:0] data
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   // Halfword lane only depends on addr_lo[1]; misaligned halves never reach here.
   assign lane_b = rdata[{addr_lo, 3'b000} +: 8];
   assign lane_h = rdata[{addr_lo[1], 4'b0000} +: 16];

   always_comb begin
      data = rdata;
      case (mem_size)
         SZ_BYTE:   data = {{(D_WIDTH-8){lane_b[7]}}, lane_b};
         SZ_BYTE_U: data = {{(D_WIDTH-8){1'b0}}, lane_b};
         SZ_HALF:   data = {{(D_WIDTH-16){lane_h[15]}}, lane_h};
         SZ_HALF_U: data = {{(D_WIDTH-16){1'b0}}, lane_h};
         default:   data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline memory-access stage: accepts one instruction at a time from execute,
// performs a load/store over the data-memory bus and produces a one-cycle
// writeback pulse per accepted instruction.
// Ports:
//   clk, rstN              clock, asynchronous active-low reset
//   in_valid .. reg_write_in  instruction from execute (captured on accept)
//   stall                  high while a memory access is outstanding
//   mem                    data-memory bus (master side)
//   wb_valid/wb_we/wb_rd/wb_data  writeback outputs (registered)
//   misalign               one-cycle pulse with the writeback of a misaligned access
//   dbg_state              current FSM state
module mem_access_stage
   import mem_definitions::*;
#(
   parameter int D_WIDTH = 32,
   parameter int A_WIDTH = 32
) (
   input  logic                clk,
   input  logic                rstN,
   input  logic                in_valid,
   input  logic [D_WIDTH-1:0]  alu_out,
   input  logic [D_WIDTH-1:0]  store_data,
   input  mem_op_t             mem_op,
   input  mem_size_t           mem_size,
   input  logic [4:0]          rd_in,
   input  logic                reg_write_in,
   output logic                stall,
   mem_access_stage_if.master  mem,
   output logic                wb_valid,
   output logic                wb_we,
   output logic [4:0]          wb_rd,
   output logic [D_WIDTH-1:0]  wb_data,
   output logic                misalign,
   output mas_state_t          dbg_state
);

   mas_state_t          state_q, state_d;
   mem_op_t             op_q;
   mem_size_t           size_q;
   logic [A_WIDTH-1:0]  addr_q;
   logic [D_WIDTH-1:0]  sdata_q;
   logic [4:0]          rd_q;
   logic                rw_q;

   logic                wb_valid_q, wb_valid_d;
   logic                wb_we_q, wb_we_d;
   logic [4:0]          wb_rd_q, wb_rd_d;
   logic [D_WIDTH-1:0]  wb_data_q, wb_data_d;
   logic                misalign_q, misalign_d;

   logic                accept, in_is_mem, in_misalign, done;
   logic [D_WIDTH-1:0]  load_data;

   assign accept      = in_valid && (state_q == ST_IDLE);
   // Illegal op encodings fall through as NONE.
   assign in_is_mem   = (mem_op == OP_LOAD) || (mem_op == OP_STORE);
   assign in_misalign = is_misaligned(mem_size, alu_out[1:0]);
   assign done        = (state_q == ST_ACCESS) && mem.mem_ready;

   // ---- FSM: state register ----
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // ---- FSM: next state ----
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (accept && in_is_mem && !in_misalign) state_d = ST_ACCESS;
         ST_ACCESS: if (mem.mem_ready) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // ---- FSM: outputs ----
   // Bus outputs are gated by the ACCESS state so reset drops them at once.
   always_comb begin
      stall         = (state_q == ST_ACCESS);
      mem.mem_req   = (state_q == ST_ACCESS);
      mem.mem_we    = 1'b0;
      mem.mem_addr  = '0;
      mem.mem_be    = '0;
      mem.mem_wdata = '0;
      if (state_q == ST_ACCESS) begin
         mem.mem_we   = (op_q == OP_STORE);
         mem.mem_addr = {addr_q[A_WIDTH-1:2], 2'b00};
         mem.mem_be   = lane_mask(size_q, addr_q[1:0]);
         case (size_q)
            SZ_BYTE, SZ_BYTE_U: mem.mem_wdata = {(D_WIDTH/8){sdata_q[7:0]}};
            SZ_HALF, SZ_HALF_U: mem.mem_wdata = {(D_WIDTH/16){sdata_q[15:0]}};
            default:            mem.mem_wdata = sdata_q;
         endcase
      end
   end

   assign dbg_state = state_q;

   // ---- instruction capture on accept ----
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         op_q    <= OP_NONE;
         size_q  <= SZ_BYTE;
         addr_q  <= '0;
         sdata_q <= '0;
         rd_q    <= '0;
         rw_q    <= 1'b0;
      end else if (accept) begin
         op_q    <= mem_op;
         size_q  <= mem_size;
         addr_q  <= alu_out[A_WIDTH-1:0];
         sdata_q <= store_data;
         rd_q    <= rd_in;
         rw_q    <= reg_write_in;
      end
   end

   load_aligner #(.D_WIDTH(D_WIDTH)) u_load_aligner (
      .rdata    (mem.mem_rdata),
      .addr_lo  (addr_q[1:0]),
      .mem_size (size_q),
      .data     (load_data)
   );

   // ---- writeback next values ----
   // NONE and misaligned ops write back directly from the accept cycle;
   // real memory ops write back from the completing mem_ready edge.
   always_comb begin
      wb_valid_d = 1'b0;
      wb_we_d    = 1'b0;
      misalign_d = 1'b0;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      if (accept) begin
         if (!in_is_mem) begin
            wb_valid_d = 1'b1;
            wb_we_d    = reg_write_in;
            wb_rd_d    = rd_in;
            wb_data_d  = alu_out;
         end else if (in_misalign) begin
            wb_valid_d = 1'b1;
            misalign_d = 1'b1;
            wb_rd_d    = rd_in;
            wb_data_d  = alu_out;
         end
      end else if (done) begin
         wb_valid_d = 1'b1;
         wb_rd_d    = rd_q;
         if (op_q == OP_LOAD) begin
            wb_we_d   = rw_q;
            wb_data_d = load_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         wb_valid_q <= 1'b0;
         wb_we_q    <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         misalign_q <= 1'b0;
      end else begin
         wb_valid_q <= wb_valid_d;
         wb_we_q    <= wb_we_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         misalign_q <= misalign_d;
      end
   end

   assign wb_valid = wb_valid_q;
   assign wb_we    = wb_we_q;
   assign wb_rd    = wb_rd_q;
   assign wb_data  = wb_data_q;
   assign misalign = misalign_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus randomized ops checked
// against a byte-level reference model and a writeback expectation queue.
module tb_mem_access_stage;
   import mem_definitions::*;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int EW = 40; // {misalign, we, rd[4:0], data_care, data[31:0]}

   // ---- clock / reset ----
   logic clk = 1'b0;
   logic rstN;
   always #5 clk = ~clk;

   logic             in_valid;
   logic [DW-1:0]    alu_out, store_data;
   mem_op_t          mem_op;
   mem_size_t        mem_size;
   logic [4:0]       rd_in;
   logic             reg_write_in;
   logic             stall, wb_valid, wb_we, misalign;
   logic [4:0]       wb_rd;
   logic [DW-1:0]    wb_data;
   mas_state_t       dbg_state;

   mem_access_stage_if #(.D_WIDTH(DW), .A_WIDTH(AW)) mif ();

   mem_access_stage #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
      .clk          (clk),
      .rstN         (rstN),
      .in_valid     (in_valid),
      .alu_out      (alu_out),
      .store_data   (store_data),
      .mem_op       (mem_op),
      .mem_size     (mem_size),
      .rd_in        (rd_in),
      .reg_write_in (reg_write_in),
      .stall        (stall),
      .mem          (mif.master),
      .wb_valid     (wb_valid),
      .wb_we        (wb_we),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .misalign     (misalign),
      .dbg_state    (dbg_state)
   );

   int total = 0;
   int bad   = 0;
   logic [EW-1:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---- reference model (byte arithmetic) ----
   function automatic int nbytes(mem_size_t s);
      case (s)
         SZ_BYTE, SZ_BYTE_U: return 1;
         SZ_HALF, SZ_HALF_U: return 2;
         default:            return 4;
      endcase
   endfunction

   function automatic bit model_misaligned(mem_size_t s, logic [31:0] a);
      return (a % nbytes(s)) != 0;
   endfunction

   function automatic logic [3:0] model_be(mem_size_t s, logic [31:0] a);
      int n = nbytes(s);
      int off = int'(a % 4);
      logic [3:0] m = '0;
      for (int i = 0; i < 4; i++) if (i >= off && i < off + n) m[i] = 1'b1;
      return m;
   endfunction

   function automatic logic [31:0] model_wdata(mem_size_t s, logic [31:0] d);
      int n = nbytes(s);
      logic [31:0] w;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
      return w;
   endfunction

   function automatic logic [31:0] model_load(mem_size_t s, logic [31:0] a, logic [31:0] r);
      int n = nbytes(s);
      int off = int'(a % 4);
      longint v = 0;
      for (int i = 0; i < n; i++) v = v + (longint'(r[8*(off+i) +: 8]) << (8*i));
      if ((s == SZ_BYTE || s == SZ_HALF) && v >= (longint'(1) << (8*n - 1)))
         v = v - (longint'(1) << (8*n));
      return v[31:0];
   endfunction

   // ---- scoreboard: writeback monitor ----
   logic [EW-1:0] e;
   always @(negedge clk) begin
      if (rstN && wb_valid) begin
         if (exp_q.size() == 0) check("wb_unexpected", 1, 0);
         else begin
            e = exp_q.pop_front();
            check("wb_misalign", misalign, e[39]);
            check("wb_we", wb_we, e[38]);
            check("wb_rd", wb_rd, e[37:33]);
            if (e[32]) check("wb_data", wb_data, e[31:0]);
         end
      end else if (misalign) begin
         check("stray_misalign", misalign, 0);
      end
   end

   // ---- driver: one instruction, called and returning at a negedge ----
   task automatic run_op(input mem_op_t op, input mem_size_t sz, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] rdv,
                         input logic [4:0] rd, input logic rw, input int waits);
      bit is_mem = (op == OP_LOAD) || (op == OP_STORE);
      bit mis    = is_mem && model_misaligned(sz, a);
      check("accept_stall", stall, 0);
      in_valid = 1'b1; mem_op = op; mem_size = sz; alu_out = a;
      store_data = sd; rd_in = rd; reg_write_in = rw;
      mif.mem_ready = 1'($urandom_range(0, 1));
      mif.mem_rdata = $urandom;
      if (!is_mem)            exp_q.push_back({1'b0, rw, rd, 1'b1, a});
      else if (mis)           exp_q.push_back({1'b1, 1'b0, rd, 1'b0, 32'h0});
      else if (op == OP_LOAD) exp_q.push_back({1'b0, rw, rd, 1'b1, model_load(sz, a, rdv)});
      else                    exp_q.push_back({1'b0, 1'b0, rd, 1'b0, 32'h0});
      @(negedge clk);
      in_valid = 1'b0;
      alu_out = $urandom; store_data = $urandom; rd_in = 5'($urandom);
      mem_op = mem_op_t'($urandom_range(0, 3)); mem_size = mem_size_t'($urandom_range(0, 4));
      if (is_mem && !mis) begin
         for (int k = 0; k <= waits; k++) begin
            check("acc_stall", stall, 1);
            check("acc_req", mif.mem_req, 1);
            check("acc_addr", mif.mem_addr, a & ~32'h3);
            check("acc_be", mif.mem_be, model_be(sz, a));
            check("acc_we", mif.mem_we, (op == OP_STORE));
            if (op == OP_STORE) check("acc_wdata", mif.mem_wdata, model_wdata(sz, sd));
            in_valid = 1'b1; // must be ignored while stalled
            mif.mem_ready = (k == waits);
            mif.mem_rdata = (k == waits) ? rdv : $urandom;
            @(negedge clk);
         end
         in_valid = 1'b0;
         mif.mem_ready = 1'b0;
      end else begin
         check("nomem_req", mif.mem_req, 0);
      end
      check("post_stall", stall, 0);
   endtask

   initial begin
      rstN = 1'b1;
      in_valid = 1'b0; alu_out = '0; store_data = '0; mem_op = OP_NONE;
      mem_size = SZ_WORD; rd_in = '0; reg_write_in = 1'b0;
      mif.mem_ready = 1'b0; mif.mem_rdata = '0;
      #1 rstN = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_stall", stall, 0);
      check("rst_req", mif.mem_req, 0);
      check("rst_we", mif.mem_we, 0);
      check("rst_addr", mif.mem_addr, 0);
      check("rst_be", mif.mem_be, 0);
      check("rst_wdata", mif.mem_wdata, 0);
      check("rst_wb_valid", wb_valid, 0);
      check("rst_wb_we", wb_we, 0);
      check("rst_wb_rd", wb_rd, 0);
      check("rst_wb_data", wb_data, 0);
      check("rst_misalign", misalign, 0);
      check("rst_state", dbg_state, ST_IDLE);
      rstN = 1'b1;

      // directed scenarios; first accept lands on the first edge after reset
      run_op(OP_NONE,  SZ_WORD,   32'h1234, 32'h0,    32'h0,         5'd5,  1'b1, 0);
      run_op(OP_LOAD,  SZ_BYTE,   32'h103,  32'h0,    32'h80FF_0000, 5'd7,  1'b1, 2);
      run_op(OP_STORE, SZ_HALF,   32'h22,   32'hABCD, 32'h0,         5'd9,  1'b1, 1);
      run_op(OP_LOAD,  SZ_WORD,   32'h6,    32'h0,    32'h0,         5'd3,  1'b1, 0);
      run_op(mem_op_t'(2'd3), SZ_HALF, 32'h55AA, 32'h0, 32'h0,      5'd11, 1'b1, 0);
      run_op(OP_STORE, SZ_HALF_U, 32'h21,   32'h1,    32'h0,         5'd12, 1'b1, 0);
      run_op(OP_LOAD,  SZ_HALF,   32'h2,    32'h0,    32'h8001_7FFF, 5'd13, 1'b1, 0);
      run_op(OP_LOAD,  SZ_BYTE_U, 32'h1,    32'h0,    32'h0000_9A00, 5'd14, 1'b0, 3);
      run_op(OP_STORE, SZ_BYTE,   32'h41,   32'h5C,   32'h0,         5'd15, 1'b1, 0);
      run_op(OP_STORE, SZ_WORD,   32'h80,   32'hDEAD_BEEF, 32'h0,    5'd16, 1'b1, 2);

      // randomized traffic
      for (int i = 0; i < 200; i++) begin
         run_op(mem_op_t'($urandom_range(0, 3)), mem_size_t'($urandom_range(0, 4)),
                $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3));
      end

      // reset while a request is outstanding: abandoned, no writeback
      in_valid = 1'b1; mem_op = OP_LOAD; mem_size = SZ_WORD; alu_out = 32'h40;
      rd_in = 5'd20; reg_write_in = 1'b1; mif.mem_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      check("rstacc_req_before", mif.mem_req, 1);
      #2 rstN = 1'b0;
      #1;
      check("rstacc_req", mif.mem_req, 0);
      check("rstacc_stall", stall, 0);
      check("rstacc_wb_valid", wb_valid, 0);
      check("rstacc_state", dbg_state, ST_IDLE);
      mif.mem_ready = 1'b1;
      @(negedge clk);
      check("rstacc_no_wb", wb_valid, 0);
      mif.mem_ready = 1'b0;
      rstN = 1'b1;
      run_op(OP_LOAD, SZ_HALF_U, 32'h0, 32'h0, 32'h0000_F00F, 5'd21, 1'b1, 1);

      repeat (3) @(negedge clk);
      check("exp_q_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter D_WIDTH, default 32, datapath width.
REQ-002 Parameter A_WIDTH, default 32, memory address width.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rstN  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  upstream execute stage presents an instruction.
REQ-006 alu_out  in  D_WIDTH  ALU result: effective address for load/store, writeback value otherwise.
REQ-007 store_data  in  D_WIDTH  rs2 value for stores.
REQ-008 mem_op  in  mem_op_t  NONE, LOAD or STORE.
REQ-009 mem_size  in  mem_size_t  BYTE, HALF, WORD, BYTE_U or HALF_U.
REQ-010 rd_in  in  5  destination register index.
REQ-011 reg_write_in  in  1  instruction writes rd.
REQ-012 stall  out  1  upstream holds its outputs while high.
REQ-013 mem_req, mem_we  out  1 each  data-memory request and write strobe.
REQ-014 mem_addr  out  A_WIDTH  word-aligned address.
REQ-015 mem_wdata  out  D_WIDTH  lane-shifted store data.
REQ-016 mem_be  out  D_WIDTH/8  byte enables.
REQ-017 mem_rdata  in  D_WIDTH  read data; valid when mem_ready is high.
REQ-018 mem_ready  in  1  memory completes the current request.
REQ-019 wb_valid, wb_we  out  1 each  writeback-stage valid and register-write enable.
REQ-020 wb_rd, wb_data  out  5, D_WIDTH  writeback index and value.
REQ-021 misalign  out  1  one-cycle pulse on a misaligned access.

Function
REQ-022 FSM SHALL have two states, IDLE and ACCESS; stall SHALL be 1 exactly when state is ACCESS.
REQ-023 Accept SHALL occur when in_valid=1 and stall=0; all inputs are registered on accept.
REQ-024 On accepting NONE, the stage SHALL drive the following next cycle: wb_valid=1, wb_data=alu_out, wb_rd=rd_in, wb_we=reg_write_in, with the FSM staying in IDLE.
REQ-025 On accepting LOAD/STORE aligned, the FSM SHALL go to ACCESS, and mem_req SHALL be 1 from the next cycle until the edge where mem_ready=1 is sampled.
REQ-026 mem_addr SHALL be {addr[A_WIDTH-1:2], 2'b00}, held stable while mem_req=1.
REQ-027 mem_be: BYTE 4'b0001<<addr[1:0]; HALF 4'b0011<<addr[1:0]; WORD 4'b1111; loads SHALL use the same mask.
REQ-028 mem_wdata SHALL be store_data replicated into the selected lanes; mem_we=1 only for STORE.
REQ-029 On the mem_ready edge, the FSM SHALL return to IDLE; the next cycle carries wb_valid=1.
REQ-030 For LOAD, wb_data SHALL be the selected lane, sign-extended (BYTE, HALF) or zero-extended (BYTE_U, HALF_U); wb_we=reg_write_in.
REQ-031 For STORE, the stage SHALL drive wb_valid=1 and wb_we=0.
REQ-032 Misaligned access: HALF with addr[0]=1, or WORD with addr[1:0]!=0.
REQ-033 A misaligned access SHALL issue no memory request and SHALL pulse misalign=1 next cycle, with wb_valid=1 and wb_we=0.
REQ-034 in_valid while stall=1 SHALL be ignored; nothing is accepted in the mem_ready cycle.
REQ-035 mem_ready while mem_req=0 SHALL be ignored.
REQ-036 wb_valid SHALL be a one-cycle pulse per accepted instruction; otherwise 0.
REQ-037 Throughput: one NONE op per cycle; memory ops take at least 3 cycles from accept to wb_valid.
REQ-038 Ops of mem_op_t illegal/default SHALL be treated as NONE.

Reset
REQ-039 rstN low SHALL immediately force state IDLE and set every output and register to 0.
REQ-040 Reset during ACCESS SHALL abandon the request; mem_req SHALL fall asynchronously and no writeback occurs.
REQ-041 The first accept SHALL be possible on the first rising edge after rstN deasserts.

Structure
REQ-042 mem_op_t and mem_size_t SHALL live in shared package mem_definitions, beside alu_definitions.
REQ-043 Lane extraction and extension SHALL be a combinational sub-module load_aligner (rdata, addr[1:0], mem_size -> data).

Verification
REQ-044 Scenario: NONE, alu_out=32'h1234, rd=5 -> next cycle wb_valid=1, wb_data=32'h1234, wb_rd=5, wb_we=1, stall=0.
REQ-045 Scenario: LOAD BYTE, addr=32'h103, rdata=32'h80FF_0000, mem_ready after 2 wait cycles -> mem_addr=32'h100, mem_be=4'b1000, wb_data=32'hFFFF_FF80; stall high throughout the wait.
REQ-046 Scenario: STORE HALF, addr=32'h22, data=32'hABCD -> mem_we=1, mem_be=4'b1100, mem_wdata=32'hABCD_ABCD, wb_we=0.
REQ-047 Scenario: LOAD WORD, addr=32'h6 -> misalign pulse, mem_req never asserted, wb_we=0.
REQ-048 Scenario: rstN low during ACCESS -> mem_req=0 immediately, no wb_valid; LOAD HALF_U, rdata=32'h0000_F00F, addr=0 after reset -> wb_data=32'h0000_F00F.
